// File: rtl/intt_result_writeback.sv
// Captures the 8-lane INTT result stream into an 8-bank x 512-row buffer and serves it
// through a 1-cycle random-access read port. Optional build macro: INTT_WB_COUNT_CHECK_EN.
module intt_result_writeback #(
    parameter int DATA_WIDTH = 39,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [279:0]          io_i_intt_concat,
    input  logic                  io_i_intt_we_result,
    input  logic [71:0]           io_i_intt_addr_result,
    input  logic                  io_i_intt_done,
    input  logic [ADDR_WIDTH-1:0] io_i_rd_addr,
    output logic [DATA_WIDTH-1:0] io_o_rd_data,
    output logic                  io_o_result_valid,
    input  logic                  io_i_release,
    output logic [9:0]            io_o_wr_count,
    output logic                  io_o_overrun,
    output logic                  io_o_count_err
);
    localparam int COEF_W = 35;
    localparam int ROW_W  = 9;
    localparam int LANES  = 8;
    localparam logic [9:0] FULL_COUNT = 10'd512;

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    state_t            state;
    state_t            state_next;
    logic              wr_accept;
    logic              wr_drop;
    logic              release_full;
    logic [9:0]        wr_count;
    logic [9:0]        wr_count_next;
    logic              overrun;
    logic [2:0]        rd_bank;
    logic [ROW_W-1:0]  rd_row;
    logic [COEF_W-1:0] bank_rd [LANES];
    logic [COEF_W-1:0] rd_data_p1;

    assign rd_bank = io_i_rd_addr[2:0];
    assign rd_row  = io_i_rd_addr[11:3];

    // Lane k always owns bank k, so all eight lanes commit in the same cycle.
    for (genvar k = 0; k < LANES; k++) begin : g_bank
        logic [COEF_W-1:0] ram [512];
        logic [ROW_W-1:0]  wr_row;

        assign wr_row = io_i_intt_addr_result[ROW_W*k +: ROW_W];

        always_ff @(posedge clock) begin
            if (wr_accept) begin
                ram[wr_row] <= io_i_intt_concat[COEF_W*k +: COEF_W];
            end
        end

        assign bank_rd[k] = ram[rd_row];
    end

    // Read stage: nonblocking RAM update gives read-first behaviour on same-cycle collisions.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_p1 <= '0;
        end else begin
            rd_data_p1 <= bank_rd[rd_bank];
        end
    end

    always_comb begin
        io_o_rd_data               = '0;
        io_o_rd_data[COEF_W-1:0]   = rd_data_p1;
    end

    always_comb begin
        state_next   = state;
        wr_accept    = 1'b0;
        wr_drop      = 1'b0;
        release_full = 1'b0;
        case (state)
            IDLE: begin
                wr_accept = io_i_intt_we_result;
                if (io_i_intt_done) begin
                    state_next = FULL;
                end else if (io_i_intt_we_result) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                wr_accept = io_i_intt_we_result;
                if (io_i_intt_done) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                // A write coinciding with release is dropped silently.
                wr_drop      = io_i_intt_we_result && !io_i_release;
                release_full = io_i_release;
                if (io_i_release) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_count_next = wr_count;
        if (release_full) begin
            wr_count_next = '0;
        end else if (wr_accept && (wr_count != FULL_COUNT)) begin
            wr_count_next = wr_count + 10'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wr_count <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_next;
            wr_count <= wr_count_next;
            if (release_full) begin
                overrun <= 1'b0;
            end else if (wr_drop) begin
                overrun <= 1'b1;
            end
        end
    end

    assign io_o_result_valid = (state == FULL);
    assign io_o_wr_count     = wr_count;
    assign io_o_overrun      = overrun;

`ifdef INTT_WB_COUNT_CHECK_EN
    logic count_err;

    // Judged on the count including a write that lands in the same cycle as done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_err <= 1'b0;
        end else if (release_full) begin
            count_err <= 1'b0;
        end else if ((state != FULL) && (state_next == FULL) && (wr_count_next != FULL_COUNT)) begin
            count_err <= 1'b1;
        end
    end

    assign io_o_count_err = count_err;
`else
    assign io_o_count_err = 1'b0;
`endif

endmodule

// File: tb/tb_intt_result_writeback.sv
// Scoreboard bench for intt_result_writeback: a queue-based reference model predicts read
// data and status; a monitor pops and compares one cycle after each issued request.
module tb_intt_result_writeback;
    localparam int DW = 39;
    localparam int AW = 12;
`ifdef INTT_WB_COUNT_CHECK_EN
    localparam bit CNT_CHECK = 1'b1;
`else
    localparam bit CNT_CHECK = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [279:0]  concat;
    logic          we;
    logic [71:0]   addrs;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          valid;
    logic          rel;
    logic [9:0]    cnt;
    logic          ovr;
    logic          cerr;

    always #5 clock = ~clock;

    intt_result_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_i_intt_concat      (concat),
        .io_i_intt_we_result   (we),
        .io_i_intt_addr_result (addrs),
        .io_i_intt_done        (done),
        .io_i_rd_addr          (rd_addr),
        .io_o_rd_data          (rd_data),
        .io_o_result_valid     (valid),
        .io_i_release          (rel),
        .io_o_wr_count         (cnt),
        .io_o_overrun          (ovr),
        .io_o_count_err        (cerr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: flat 4096-entry address space, state 0=empty 1=filling 2=full.
    logic [34:0] m_mem [4096];
    bit          m_known [4096];
    int          m_state;
    int          m_cnt;
    bit          m_ovr;
    bit          m_cerr;

    logic [34:0] ld [8];
    logic [8:0]  la [8];

    typedef struct packed {
        logic       v;
        logic [9:0] c;
        logic       o;
        logic       e;
    } st_t;

    logic [DW-1:0] rd_q [$];
    st_t           st_q [$];
    logic rd_en = 1'b0;
    logic st_en = 1'b0;
    logic rd_en_d = 1'b0;
    logic st_en_d = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clock) begin
        rd_en_d <= rd_en;
        st_en_d <= st_en;
    end

    always @(negedge clock) begin
        if (rd_en_d) begin
            if (rd_q.size() == 0) begin
                check("rd_queue_underflow", 64'd1, 64'd0);
            end else begin
                check("rd_data", 64'(rd_data), 64'(rd_q.pop_front()));
            end
        end
        if (st_en_d) begin
            if (st_q.size() == 0) begin
                check("st_queue_underflow", 64'd1, 64'd0);
            end else begin
                st_t e;
                e = st_q.pop_front();
                check("result_valid", 64'(valid), 64'(e.v));
                check("wr_count", 64'(cnt), 64'(e.c));
                check("overrun", 64'(ovr), 64'(e.o));
                check("count_err", 64'(cerr), 64'(e.e));
            end
        end
    end

    task automatic cycle(input bit w, input bit d, input bit r, input logic [AW-1:0] ra,
                         input bit crd, input bit cst);
        bit acc;
        bit rel_full;
        st_t e;
        we      = w;
        done    = d;
        rel     = r;
        rd_addr = ra;
        for (int k = 0; k < 8; k++) begin
            concat[35*k +: 35] = ld[k];
            addrs[9*k +: 9]    = la[k];
        end
        rd_en = crd && m_known[ra];
        if (rd_en) rd_q.push_back(DW'(m_mem[ra]));

        acc      = w && (m_state != 2);
        rel_full = r && (m_state == 2);
        if (acc) begin
            for (int k = 0; k < 8; k++) begin
                m_mem[int'(la[k]) * 8 + k]   = ld[k];
                m_known[int'(la[k]) * 8 + k] = 1'b1;
            end
        end
        if (rel_full) m_cnt = 0;
        else if (acc && m_cnt < 512) m_cnt++;
        if (rel_full) m_ovr = 1'b0;
        else if (w && m_state == 2) m_ovr = 1'b1;
        if (rel_full) m_cerr = 1'b0;
        else if (m_state != 2 && d && m_cnt != 512 && CNT_CHECK) m_cerr = 1'b1;
        if (rel_full) m_state = 0;
        else if (m_state != 2 && d) m_state = 2;
        else if (m_state == 0 && w) m_state = 1;

        st_en = cst;
        if (cst) begin
            e.v = (m_state == 2);
            e.c = 10'(m_cnt);
            e.o = m_ovr;
            e.e = m_cerr;
            st_q.push_back(e);
        end
        @(posedge clock);
        #2;
    endtask

    task automatic set_lanes(input logic [34:0] data, input logic [8:0] row);
        for (int k = 0; k < 8; k++) begin
            ld[k] = data;
            la[k] = row;
        end
    endtask

    task automatic rand_lanes();
        for (int k = 0; k < 8; k++) begin
            ld[k] = 35'({$urandom(), $urandom()});
            la[k] = 9'($urandom_range(0, 511));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_data"}, 64'(rd_data), 64'd0);
        check({tag, "_result_valid"}, 64'(valid), 64'd0);
        check({tag, "_wr_count"}, 64'(cnt), 64'd0);
        check({tag, "_overrun"}, 64'(ovr), 64'd0);
        check({tag, "_count_err"}, 64'(cerr), 64'd0);
    endtask

    initial begin
        we = 1'b0; done = 1'b0; rel = 1'b0; rd_addr = '0; concat = '0; addrs = '0;
        m_state = 0; m_cnt = 0; m_ovr = 1'b0; m_cerr = 1'b0;
        for (int i = 0; i < 4096; i++) m_known[i] = 1'b0;
        set_lanes(35'd0, 9'd0);

        #2 reset = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;

        // Full polynomial: lane k, row r carries 512k + r.
        for (int row = 0; row < 512; row++) begin
            for (int k = 0; k < 8; k++) begin
                ld[k] = 35'(512 * k + row);
                la[k] = 9'(row);
            end
            cycle(1'b1, 1'b0, 1'b0, 12'($urandom_range(0, 8 * row + 7)), 1'b1, (row % 64) == 0);
        end
        cycle(1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 12'($urandom_range(0, 4095)), 1'b1, 1'b1);
        end
        cycle(1'b0, 1'b1, 1'b0, 12'd9, 1'b1, 1'b1);

        // Overrun in FULL leaves RAM and count untouched.
        set_lanes(35'h123, 9'd0);
        cycle(1'b1, 1'b0, 1'b0, 12'd0, 1'b1, 1'b1);
        for (int a = 0; a < 8; a++) cycle(1'b0, 1'b0, 1'b0, 12'(a), 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 12'd0, 1'b0, 1'b1);

        // Read-first collision on row 5, bank 0.
        set_lanes(35'h7_FFFF_FFFF, 9'd5);
        cycle(1'b1, 1'b0, 1'b0, 12'd40, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 12'd40, 1'b1, 1'b0);

        // Short transform of 10 writes.
        for (int i = 0; i < 9; i++) begin
            rand_lanes();
            cycle(1'b1, 1'b0, 1'b0, 12'($urandom_range(0, 4095)), 1'b1, 1'b1);
        end
        cycle(1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 12'd0, 1'b0, 1'b1);

        // Write and done together from IDLE, then overrun cleared by release+write.
        rand_lanes();
        cycle(1'b1, 1'b1, 1'b0, 12'd0, 1'b0, 1'b1);
        rand_lanes();
        cycle(1'b1, 1'b0, 1'b0, 12'd0, 1'b0, 1'b1);
        rand_lanes();
        cycle(1'b1, 1'b0, 1'b1, 12'($urandom_range(0, 4095)), 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 12'($urandom_range(0, 4095)), 1'b1, 1'b1);

        for (int i = 0; i < 300; i++) begin
            rand_lanes();
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                  12'($urandom_range(0, 4095)), 1'b1, 1'b1);
        end
        cycle(1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 12'd0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a fill.
        for (int i = 0; i < 300; i++) begin
            rand_lanes();
            cycle(1'b1, 1'b0, 1'b0, 12'($urandom_range(0, 4095)), 1'b1, i == 299);
        end
        cycle(1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0);
        reset = 1'b1;
        #1 check_reset_outputs("midreset");
        m_state = 0; m_cnt = 0; m_ovr = 1'b0; m_cerr = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        rand_lanes();
        cycle(1'b1, 1'b0, 1'b0, 12'($urandom_range(0, 4095)), 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 12'($urandom_range(0, 4095)), 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0);

        check("queues_drained", 64'(rd_q.size() + st_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
